exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute pipeline stage. Holds the ID/EX pipeline register.
- Selects and drives the operands and 5-bit opcode into the combinational ALU, and takes the ALU result back.
- Issues data-memory requests using a req/addr_ok handshake.
- Forwards results to decode, and hands the instruction to MEM using the valid/allowin protocol.

Parameters:
- PC_W, 32, width of PC and data paths.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- flush  in  1  exception/eret flush; kills the instruction held in this stage
- ds_to_es_valid  in  1  decode has an instruction
- es_allowin  out  1  stage can accept
- ds_pc  in  32  instruction PC
- ds_aluop  in  5  ALU opcode: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui
- ds_src1_is_sa  in  1  src1 = shamt
- ds_src1_is_pc  in  1  src1 = PC
- ds_src2_is_imm  in  1  src2 = immediate
- ds_src2_is_8  in  1  src2 = 8 (link)
- ds_imm_zext  in  1  zero-extend immediate (else sign-extend)
- ds_imm  in  16  instruction[15:0]
- ds_rs_value  in  32  rs operand
- ds_rt_value  in  32  rt operand / store data
- ds_dest  in  5  destination GPR
- ds_gr_we  in  1  writes a GPR
- ds_mem_we  in  1  store
- ds_res_from_mem  in  1  load
- ds_mem_size  in  2  0 byte, 1 half, 2 word
- alu_op  out  5  to ALU
- alu_src1  out  32  to ALU
- alu_src2  out  32  to ALU
- alu_result  in  32  from ALU, combinational
- data_req  out  1  memory request
- data_wr  out  1  1 = store
- data_wstrb  out  4  byte enables
- data_addr  out  32  byte address (= alu_result)
- data_wdata  out  32  store data
- data_addr_ok  in  1  request accepted this cycle
- es_to_ms_valid  out  1  to MEM
- ms_allowin  in  1  MEM can accept
- es_pc, es_result  out  32  to MEM
- es_dest  out  5  to MEM
- es_gr_we, es_res_from_mem, es_ade  out  1  to MEM
- es_fwd_we  out  1  bypass valid (es_valid & es_gr_we & ~es_res_from_mem)
- es_fwd_dest  out  5  bypass destination
- es_fwd_data  out  32  bypass data
- es_load_stall  out  1  es_valid & es_res_from_mem & es_dest≠0 (decode must stall dependents)

Behaviour:
- Reset: asynchronous, active-low (resetn low clears immediately). Clears es_valid, req_sent and all held fields to 0. All outputs 0 except es_allowin=1.
- Handshake:
  - es_allowin = ~es_valid | (es_ready_go & ms_allowin).
  - On clk, if es_allowin: es_valid <= ds_to_es_valid & ~flush.
  - Payload latches only when es_allowin & ds_to_es_valid.
  - es_to_ms_valid = es_valid & es_ready_go & ~flush.
- Operands:
  - alu_src1 = sa ? {27'b0, imm[10:6]} : pc_sel ? es_pc : rs.
  - alu_src2 = is_8 ? 32'd8 : is_imm ? (zext ? {16'b0, imm} : {{16{imm[15]}}, imm}) : rt.
  - alu_op = held aluop.
  - es_result = alu_result.
- Address error:
  - es_ade = mem op & ((size==1 & addr[0]) | (size==2 & addr[1:0]≠0)).
  - An ade instruction never requests memory; it passes to MEM immediately.
- Memory request:
  - data_req = es_valid & (mem_we|res_from_mem) & ~es_ade & ~req_sent & ~flush.
  - data_addr = alu_result. data_wr = mem_we.
- Store data/strobes:
  - byte: wdata = {4{rt[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{rt[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - word: wdata = rt, wstrb = 1111.
  - Loads: wstrb = 0000.
- req_sent:
  - Set on data_req & data_addr_ok.
  - Cleared when the instruction leaves the stage (es_to_ms_valid & ms_allowin) or on flush.
- es_ready_go = ~memop | es_ade | req_sent | (data_req & data_addr_ok).
  - A request stalled by ~data_addr_ok holds data_req and the address/data stable until accepted.
- Flush:
  - Same cycle: es_to_ms_valid=0, data_req=0.
  - Next edge: es_valid=0.
  - A request already accepted is not recalled; MEM drops its response.
- Simultaneous flush & ds_to_es_valid: the incoming instruction is discarded.
- Back-pressure (ms_allowin=0): the instruction is held. data_req does not repeat once req_sent=1.
- es_fwd_data = alu_result. es_fwd_dest = es_dest.

Test Plan:
- ADDIU: rs=0x7FFFFFFF, imm=0x0001, sext, aluop=0 -> alu_src2=0x00000001; es_result=0x80000000 forwarded same cycle; es_to_ms_valid one cycle after acceptance.
- SLL: sa=5, rt=0x1 (src1_is_sa, aluop=8) -> alu_src1=0x5, alu_src2=0x1.
- JAL link: src1_is_pc, src2_is_8, pc=0xBFC00010 -> alu_src1=0xBFC00010, alu_src2=8.
- SB: addr=0x1003, rt=0xAB -> data_wstrb=1000, data_wdata=0xABABABAB. With data_addr_ok held low 3 cycles: data_req held high 3 cycles, es_allowin=0, one accept, then advance.
- LW addr=0x1002 -> es_ade=1, data_req never asserts, passes to MEM next cycle. LW addr=0x1000 -> es_load_stall=1 while held.
- Flush while data_req pending -> data_req low same cycle, es_valid 0 next edge. resetn asserted mid-stall -> all outputs 0 immediately, es_allowin=1.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: holds the ID/EX register, steers operands into the external
// ALU, issues data-memory requests over req/addr_ok and hands results to MEM.
module exe_stage #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            ds_to_es_valid,
   output logic            es_allowin,
   input  logic [PC_W-1:0] ds_pc,
   input  logic [4:0]      ds_aluop,
   input  logic            ds_src1_is_sa,
   input  logic            ds_src1_is_pc,
   input  logic            ds_src2_is_imm,
   input  logic            ds_src2_is_8,
   input  logic            ds_imm_zext,
   input  logic [15:0]     ds_imm,
   input  logic [PC_W-1:0] ds_rs_value,
   input  logic [PC_W-1:0] ds_rt_value,
   input  logic [4:0]      ds_dest,
   input  logic            ds_gr_we,
   input  logic            ds_mem_we,
   input  logic            ds_res_from_mem,
   input  logic [1:0]      ds_mem_size,
   output logic [4:0]      alu_op,
   output logic [PC_W-1:0] alu_src1,
   output logic [PC_W-1:0] alu_src2,
   input  logic [PC_W-1:0] alu_result,
   output logic            data_req,
   output logic            data_wr,
   output logic [3:0]      data_wstrb,
   output logic [PC_W-1:0] data_addr,
   output logic [PC_W-1:0] data_wdata,
   input  logic            data_addr_ok,
   output logic            es_to_ms_valid,
   input  logic            ms_allowin,
   output logic [PC_W-1:0] es_pc,
   output logic [PC_W-1:0] es_result,
   output logic [4:0]      es_dest,
   output logic            es_gr_we,
   output logic            es_res_from_mem,
   output logic            es_ade,
   output logic            es_fwd_we,
   output logic [4:0]      es_fwd_dest,
   output logic [PC_W-1:0] es_fwd_data,
   output logic            es_load_stall
);

   logic            es_valid;
   logic            req_sent;
   logic            es_ready_go;
   logic            mem_op;
   logic            leave;
   logic [4:0]      es_aluop;
   logic            es_src1_is_sa;
   logic            es_src1_is_pc;
   logic            es_src2_is_imm;
   logic            es_src2_is_8;
   logic            es_imm_zext;
   logic [15:0]     es_imm;
   logic [PC_W-1:0] es_rs;
   logic [PC_W-1:0] es_rt;
   logic            es_mem_we;
   logic [1:0]      es_mem_size;

   // Valid bit: flush always kills the held instruction, even when stalled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid <= 1'b0;
      end else if (flush) begin
         es_valid <= 1'b0;
      end else if (es_allowin) begin
         es_valid <= ds_to_es_valid;
      end
   end

   // ID/EX payload register, loaded only when a new instruction is taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_pc           <= '0;
         es_aluop        <= '0;
         es_src1_is_sa   <= 1'b0;
         es_src1_is_pc   <= 1'b0;
         es_src2_is_imm  <= 1'b0;
         es_src2_is_8    <= 1'b0;
         es_imm_zext     <= 1'b0;
         es_imm          <= '0;
         es_rs           <= '0;
         es_rt           <= '0;
         es_dest         <= '0;
         es_gr_we        <= 1'b0;
         es_mem_we       <= 1'b0;
         es_res_from_mem <= 1'b0;
         es_mem_size     <= '0;
      end else if (es_allowin && ds_to_es_valid) begin
         es_pc           <= ds_pc;
         es_aluop        <= ds_aluop;
         es_src1_is_sa   <= ds_src1_is_sa;
         es_src1_is_pc   <= ds_src1_is_pc;
         es_src2_is_imm  <= ds_src2_is_imm;
         es_src2_is_8    <= ds_src2_is_8;
         es_imm_zext     <= ds_imm_zext;
         es_imm          <= ds_imm;
         es_rs           <= ds_rs_value;
         es_rt           <= ds_rt_value;
         es_dest         <= ds_dest;
         es_gr_we        <= ds_gr_we;
         es_mem_we       <= ds_mem_we;
         es_res_from_mem <= ds_res_from_mem;
         es_mem_size     <= ds_mem_size;
      end
   end

   // Remembers an accepted memory request so it is never issued twice;
   // leaving the stage wins over a same-cycle accept.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_sent <= 1'b0;
      end else if (leave || flush) begin
         req_sent <= 1'b0;
      end else if (data_req && data_addr_ok) begin
         req_sent <= 1'b1;
      end
   end

   // Operand steering into the ALU.
   always_comb begin
      alu_op = es_aluop;
      if (es_src1_is_sa) begin
         alu_src1 = {{(PC_W-5){1'b0}}, es_imm[10:6]};
      end else if (es_src1_is_pc) begin
         alu_src1 = es_pc;
      end else begin
         alu_src1 = es_rs;
      end
      if (es_src2_is_8) begin
         alu_src2 = 32'd8;
      end else if (es_src2_is_imm) begin
         alu_src2 = es_imm_zext ? {16'b0, es_imm} : {{16{es_imm[15]}}, es_imm};
      end else begin
         alu_src2 = es_rt;
      end
   end

   // Alignment check, request handshake and pipeline handoff.
   always_comb begin
      mem_op = es_mem_we | es_res_from_mem;
      es_ade = mem_op & (((es_mem_size == 2'd1) & alu_result[0]) |
                         ((es_mem_size == 2'd2) & (alu_result[1:0] != 2'b00)));
      data_req       = es_valid & mem_op & ~es_ade & ~req_sent & ~flush;
      data_wr        = es_mem_we;
      data_addr      = alu_result;
      es_ready_go    = ~mem_op | es_ade | req_sent | (data_req & data_addr_ok);
      es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
      es_to_ms_valid = es_valid & es_ready_go & ~flush;
      leave          = es_to_ms_valid & ms_allowin;
   end

   // Store data replication and byte enables; loads drive no strobes.
   always_comb begin
      data_wdata = es_rt;
      data_wstrb = 4'b0000;
      case (es_mem_size)
         2'd0: begin
            data_wdata = {4{es_rt[7:0]}};
            data_wstrb = 4'b0001 << alu_result[1:0];
         end
         2'd1: begin
            data_wdata = {2{es_rt[15:0]}};
            data_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            data_wdata = es_rt;
            data_wstrb = 4'b1111;
         end
      endcase
      if (!es_mem_we) begin
         data_wstrb = 4'b0000;
      end
   end

   // Results toward MEM and the decode bypass network.
   always_comb begin
      es_result     = alu_result;
      es_fwd_we     = es_valid & es_gr_we & ~es_res_from_mem;
      es_fwd_dest   = es_dest;
      es_fwd_data   = alu_result;
      es_load_stall = es_valid & es_res_from_mem & (es_dest != 5'd0);
   end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a behavioural ALU on the side.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        ds_to_es_valid;
   logic        es_allowin;
   logic [31:0] ds_pc;
   logic [4:0]  ds_aluop;
   logic        ds_src1_is_sa, ds_src1_is_pc, ds_src2_is_imm, ds_src2_is_8, ds_imm_zext;
   logic [15:0] ds_imm;
   logic [31:0] ds_rs_value, ds_rt_value;
   logic [4:0]  ds_dest;
   logic        ds_gr_we, ds_mem_we, ds_res_from_mem;
   logic [1:0]  ds_mem_size;
   logic [4:0]  alu_op;
   logic [31:0] alu_src1, alu_src2, alu_result;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok;
   logic        es_to_ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc, es_result;
   logic [4:0]  es_dest;
   logic        es_gr_we, es_res_from_mem, es_ade;
   logic        es_fwd_we;
   logic [4:0]  es_fwd_dest;
   logic [31:0] es_fwd_data;
   logic        es_load_stall;

   int errors = 0;
   int checks = 0;
   int accepts = 0;

   always #5 clk = ~clk;

   exe_stage #(.PC_W(32)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
      .ds_pc(ds_pc), .ds_aluop(ds_aluop),
      .ds_src1_is_sa(ds_src1_is_sa), .ds_src1_is_pc(ds_src1_is_pc),
      .ds_src2_is_imm(ds_src2_is_imm), .ds_src2_is_8(ds_src2_is_8),
      .ds_imm_zext(ds_imm_zext), .ds_imm(ds_imm),
      .ds_rs_value(ds_rs_value), .ds_rt_value(ds_rt_value),
      .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .ds_mem_we(ds_mem_we),
      .ds_res_from_mem(ds_res_from_mem), .ds_mem_size(ds_mem_size),
      .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
      .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem), .es_ade(es_ade),
      .es_fwd_we(es_fwd_we), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data),
      .es_load_stall(es_load_stall)
   );

   // External combinational ALU.
   always_comb begin
      case (alu_op)
         5'd0:    alu_result = alu_src1 + alu_src2;
         5'd1:    alu_result = alu_src1 - alu_src2;
         5'd2:    alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
         5'd3:    alu_result = {31'b0, alu_src1 < alu_src2};
         5'd4:    alu_result = alu_src1 & alu_src2;
         5'd5:    alu_result = ~(alu_src1 | alu_src2);
         5'd6:    alu_result = alu_src1 | alu_src2;
         5'd7:    alu_result = alu_src1 ^ alu_src2;
         5'd8:    alu_result = alu_src2 << alu_src1[4:0];
         5'd9:    alu_result = alu_src2 >> alu_src1[4:0];
         5'd10:   alu_result = $signed(alu_src2) >>> alu_src1[4:0];
         5'd11:   alu_result = {alu_src2[15:0], 16'b0};
         default: alu_result = 32'b0;
      endcase
   end

   always @(posedge clk) begin
      if (resetn && data_req && data_addr_ok) accepts = accepts + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] op,
                        input logic sa, input logic ispc, input logic isimm,
                        input logic is8, input logic zext, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] dest,
                        input logic gwe, input logic mwe, input logic rfm, input logic [1:0] sz);
      ds_to_es_valid = 1'b1;
      ds_pc = pc; ds_aluop = op;
      ds_src1_is_sa = sa; ds_src1_is_pc = ispc; ds_src2_is_imm = isimm;
      ds_src2_is_8 = is8; ds_imm_zext = zext; ds_imm = imm;
      ds_rs_value = rs; ds_rt_value = rt; ds_dest = dest;
      ds_gr_we = gwe; ds_mem_we = mwe; ds_res_from_mem = rfm; ds_mem_size = sz;
   endtask

   // Present an instruction at a falling edge; it is taken on the next rising edge.
   // Returns just after the following falling edge with decode idle.
   task automatic issue(input logic [31:0] pc, input logic [4:0] op,
                        input logic sa, input logic ispc, input logic isimm,
                        input logic is8, input logic zext, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] dest,
                        input logic gwe, input logic mwe, input logic rfm, input logic [1:0] sz);
      @(negedge clk);
      drive(pc, op, sa, ispc, isimm, is8, zext, imm, rs, rt, dest, gwe, mwe, rfm, sz);
      @(posedge clk);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; ms_allowin = 1'b1;
      drive(32'h0, 5'd0, 0, 0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 2'd0);
      ds_to_es_valid = 1'b0;
      #3;
      chk("rst_allowin", {31'b0, es_allowin}, 32'h1);
      chk("rst_to_ms", {31'b0, es_to_ms_valid}, 32'h0);
      chk("rst_req", {31'b0, data_req}, 32'h0);
      chk("rst_src1", alu_src1, 32'h0);
      chk("rst_fwd_we", {31'b0, es_fwd_we}, 32'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // ADDIU: 0x7FFFFFFF + sext(1)
      @(negedge clk);
      drive(32'hBFC00000, 5'd0, 0, 0, 1, 0, 0, 16'h0001, 32'h7FFFFFFF, 32'h0, 5'd2, 1, 0, 0, 2'd0);
      #1;
      chk("addiu_pre_to_ms", {31'b0, es_to_ms_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
      chk("addiu_src2", alu_src2, 32'h00000001);
      chk("addiu_result", es_result, 32'h80000000);
      chk("addiu_fwd_data", es_fwd_data, 32'h80000000);
      chk("addiu_fwd_we", {31'b0, es_fwd_we}, 32'h1);
      chk("addiu_fwd_dest", {27'b0, es_fwd_dest}, 32'd2);
      chk("addiu_to_ms", {31'b0, es_to_ms_valid}, 32'h1);
      @(negedge clk);
      #1;
      chk("addiu_gone", {31'b0, es_to_ms_valid}, 32'h0);

      // SLL rt=1 by 5
      issue(32'hBFC00004, 5'd8, 1, 0, 0, 0, 0, 16'h0140, 32'h0, 32'h1, 5'd3, 1, 0, 0, 2'd0);
      chk("sll_src1", alu_src1, 32'h5);
      chk("sll_src2", alu_src2, 32'h1);
      chk("sll_result", es_result, 32'h20);

      // JAL link: pc + 8
      issue(32'hBFC00010, 5'd0, 0, 1, 0, 1, 0, 16'h0, 32'h0, 32'h0, 5'd31, 1, 0, 0, 2'd0);
      chk("jal_src1", alu_src1, 32'hBFC00010);
      chk("jal_src2", alu_src2, 32'h8);
      chk("jal_result", es_result, 32'hBFC00018);

      // SB to 0x1003 with addr_ok held low for three cycles
      issue(32'hBFC00020, 5'd0, 0, 0, 1, 0, 0, 16'h0003, 32'h1000, 32'h123456AB, 5'd0, 0, 1, 0, 2'd0);
      chk("sb_addr", data_addr, 32'h1003);
      chk("sb_wstrb", {28'b0, data_wstrb}, 32'h8);
      chk("sb_wdata", data_wdata, 32'hABABABAB);
      chk("sb_wr", {31'b0, data_wr}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         chk("sb_req_wait", {31'b0, data_req}, 32'h1);
         chk("sb_allowin_wait", {31'b0, es_allowin}, 32'h0);
         chk("sb_to_ms_wait", {31'b0, es_to_ms_valid}, 32'h0);
      end
      @(negedge clk);
      data_addr_ok = 1'b1;
      #1;
      chk("sb_req_acc", {31'b0, data_req}, 32'h1);
      chk("sb_to_ms_acc", {31'b0, es_to_ms_valid}, 32'h1);
      chk("sb_allowin_acc", {31'b0, es_allowin}, 32'h1);
      @(negedge clk);
      data_addr_ok = 1'b0;
      #1;
      chk("sb_req_after", {31'b0, data_req}, 32'h0);
      chk("sb_accepts", accepts, 32'd1);

      // SH to 0x2006 under MEM back-pressure; request accepted at once, not repeated
      ms_allowin = 1'b0;
      data_addr_ok = 1'b1;
      issue(32'hBFC00030, 5'd0, 0, 0, 1, 0, 0, 16'h0006, 32'h2000, 32'h1234BEEF, 5'd0, 0, 1, 0, 2'd1);
      chk("sh_wstrb", {28'b0, data_wstrb}, 32'hC);
      chk("sh_wdata", data_wdata, 32'hBEEFBEEF);
      chk("sh_req", {31'b0, data_req}, 32'h1);
      @(negedge clk);
      #1;
      chk("sh_req_norepeat", {31'b0, data_req}, 32'h0);
      chk("sh_to_ms_held", {31'b0, es_to_ms_valid}, 32'h1);
      chk("sh_allowin_held", {31'b0, es_allowin}, 32'h0);
      chk("sh_accepts", accepts, 32'd2);
      ms_allowin = 1'b1;
      @(negedge clk);
      #1;
      chk("sh_gone", {31'b0, es_to_ms_valid}, 32'h0);

      // LW to 0x1002: misaligned, no request, straight to MEM
      issue(32'hBFC00040, 5'd0, 0, 0, 1, 0, 0, 16'h0002, 32'h1000, 32'h0, 5'd4, 1, 0, 1, 2'd2);
      chk("lw_ade", {31'b0, es_ade}, 32'h1);
      chk("lw_ade_req", {31'b0, data_req}, 32'h0);
      chk("lw_ade_to_ms", {31'b0, es_to_ms_valid}, 32'h1);
      chk("lw_ade_accepts", accepts, 32'd2);
      data_addr_ok = 1'b0;

      // LW to 0x1000 stalled, then flushed
      issue(32'hBFC00044, 5'd0, 0, 0, 1, 0, 0, 16'h0000, 32'h1000, 32'h0, 5'd5, 1, 0, 1, 2'd2);
      chk("lw_load_stall", {31'b0, es_load_stall}, 32'h1);
      chk("lw_req", {31'b0, data_req}, 32'h1);
      chk("lw_wstrb", {28'b0, data_wstrb}, 32'h0);
      chk("lw_fwd_we", {31'b0, es_fwd_we}, 32'h0);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_req", {31'b0, data_req}, 32'h0);
      chk("flush_to_ms", {31'b0, es_to_ms_valid}, 32'h0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_valid_gone", {31'b0, es_load_stall}, 32'h0);
      chk("flush_allowin", {31'b0, es_allowin}, 32'h1);

      // Flush coincident with an incoming instruction discards it
      @(negedge clk);
      drive(32'hBFC00050, 5'd0, 0, 0, 1, 0, 0, 16'h0001, 32'h1, 32'h0, 5'd6, 1, 0, 0, 2'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      ds_to_es_valid = 1'b0;
      #1;
      chk("flush_in_to_ms", {31'b0, es_to_ms_valid}, 32'h0);
      chk("flush_in_fwd_we", {31'b0, es_fwd_we}, 32'h0);

      // Reset asserted mid-stall
      issue(32'hBFC00060, 5'd0, 0, 0, 1, 0, 0, 16'h0000, 32'h1000, 32'h0, 5'd7, 1, 0, 1, 2'd2);
      chk("rst_mid_req_pre", {31'b0, data_req}, 32'h1);
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_mid_req", {31'b0, data_req}, 32'h0);
      chk("rst_mid_allowin", {31'b0, es_allowin}, 32'h1);
      chk("rst_mid_stall", {31'b0, es_load_stall}, 32'h0);
      chk("rst_mid_pc", es_pc, 32'h0);
      chk("rst_mid_src1", alu_src1, 32'h0);
      chk("rst_mid_dest", {27'b0, es_dest}, 32'h0);
      chk("rst_mid_rfm", {31'b0, es_res_from_mem}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
